// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide control slice.
// Holds op encodings, divider latency default and the metadata record.
package div_pkg;

  localparam int DIV_LATENCY = 7;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Per-op metadata travelling beside the divider; tag rides separately
  // since its width is a block parameter.
  typedef struct packed {
    logic        valid;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic        ovf;
    logic [31:0] rs1;
  } meta_t;

endpackage

// File: rtl/div_meta_pipe.sv
// Metadata shift register aligned with the pipelined divider.
// Ports: clk, rst, flush_i, in_i/in_tag_i (stage 0), out_o/out_tag_o
// (last stage), any_valid_o (OR of all stage valids).
module div_meta_pipe
  import div_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  meta_t            in_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output meta_t            out_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             any_valid_o
);

  meta_t            meta_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      meta_q[0] <= in_i;
      tag_q[0]  <= in_tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        meta_q[i] <= meta_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
      // Data keeps moving; only the valids are killed.
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          meta_q[i].valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid_o = any_valid_o | meta_q[i].valid;
    end
  end

  assign out_o     = meta_q[DEPTH-1];
  assign out_tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/rv32m_div_ctrl.sv
// Sign front/back-end for RV32M DIV/DIVU/REM/REMU around an unsigned divider.
// Ports: clk, rst, i_valid/i_op/i_rs1/i_rs2/i_tag/i_flush issue side;
// o_div_dividend/o_div_divisor and i_div_quotient/i_div_remainder divider
// side; o_valid/o_result/o_tag writeback; o_busy hazard hint.
// Macro DIV_RESULT_REG_EN registers the writeback outputs (+1 latency).
module rv32m_div_ctrl #(
  parameter int DIV_LATENCY = div_pkg::DIV_LATENCY,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic [31:0]      o_div_dividend,
  output logic [31:0]      o_div_divisor,
  input  logic [31:0]      i_div_quotient,
  input  logic [31:0]      i_div_remainder,
  output logic             o_valid,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  import div_pkg::*;

  logic is_sgn;
  logic a_neg;
  logic b_neg;
  meta_t            meta_in;
  meta_t            meta_out;
  logic [TAG_W-1:0] tag_out;
  logic             pipe_busy;
  logic [31:0]      quo;
  logic [31:0]      rem;
  logic [31:0]      res;

  assign is_sgn = ~i_op[0];
  assign a_neg  = is_sgn & i_rs1[31];
  assign b_neg  = is_sgn & i_rs2[31];

  // INT_MIN negates to itself, which is already its unsigned magnitude.
  assign o_div_dividend = a_neg ? (~i_rs1 + 32'd1) : i_rs1;
  assign o_div_divisor  = b_neg ? (~i_rs2 + 32'd1) : i_rs2;

  always_comb begin
    meta_in        = '0;
    meta_in.valid  = i_valid & ~i_flush;
    meta_in.is_rem = i_op[1];
    meta_in.neg_q  = a_neg ^ b_neg;
    meta_in.neg_r  = a_neg;
    meta_in.dz     = (i_rs2 == 32'd0);
    meta_in.ovf    = is_sgn & (i_rs1 == INT_MIN)
                   & (i_rs2 == ALL_ONES);
    meta_in.rs1    = i_rs1;
  end

  div_meta_pipe #(
    .DEPTH (DIV_LATENCY),
    .TAG_W (TAG_W)
  ) u_meta (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (i_flush),
    .in_i        (meta_in),
    .in_tag_i    (i_tag),
    .out_o       (meta_out),
    .out_tag_o   (tag_out),
    .any_valid_o (pipe_busy)
  );

  always_comb begin
    quo = i_div_quotient;
    rem = i_div_remainder;
    if (meta_out.dz) begin
      quo = ALL_ONES;
      rem = meta_out.rs1;
    end else if (meta_out.ovf) begin
      quo = INT_MIN;
      rem = 32'd0;
    end else begin
      if (meta_out.neg_q) quo = ~i_div_quotient + 32'd1;
      if (meta_out.neg_r) rem = ~i_div_remainder + 32'd1;
    end
    res = meta_out.is_rem ? rem : quo;
  end

`ifdef DIV_RESULT_REG_EN
  logic             valid_q;
  logic [31:0]      result_q;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      valid_q  <= meta_out.valid;
      result_q <= meta_out.valid ? res : '0;
      tag_q    <= meta_out.valid ? tag_out : '0;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_tag    = tag_q;
  assign o_busy   = pipe_busy | valid_q;
`else
  assign o_valid  = meta_out.valid;
  assign o_result = meta_out.valid ? res : '0;
  assign o_tag    = meta_out.valid ? tag_out : '0;
  assign o_busy   = pipe_busy;
`endif

endmodule

// File: tb/tb_rv32m_div_ctrl.sv
// Scoreboard bench for rv32m_div_ctrl with a behavioural 7-stage divider.
// Directed vectors; a negedge monitor pops expected results.
module tb_rv32m_div_ctrl;
  import div_pkg::*;

`ifdef DIV_RESULT_REG_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 7;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [4:0]  i_tag;
  logic        i_flush;
  logic [31:0] o_div_dividend;
  logic [31:0] o_div_divisor;
  logic [31:0] i_div_quotient;
  logic [31:0] i_div_remainder;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic        o_busy;

  always #5 clk = ~clk;

  rv32m_div_ctrl #(.DIV_LATENCY(7), .TAG_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .i_op            (i_op),
    .i_rs1           (i_rs1),
    .i_rs2           (i_rs2),
    .i_tag           (i_tag),
    .i_flush         (i_flush),
    .o_div_dividend  (o_div_dividend),
    .o_div_divisor   (o_div_divisor),
    .i_div_quotient  (i_div_quotient),
    .i_div_remainder (i_div_remainder),
    .o_valid         (o_valid),
    .o_result        (o_result),
    .o_tag           (o_tag),
    .o_busy          (o_busy)
  );

  // Behavioural unsigned divider: samples inputs, result after 7 edges.
  logic [31:0] da [7];
  logic [31:0] db [7];
  always @(posedge clk) begin
    da[0] <= o_div_dividend;
    db[0] <= o_div_divisor;
    for (int i = 1; i < 7; i++) begin
      da[i] <= da[i-1];
      db[i] <= db[i-1];
    end
  end
  assign i_div_quotient  = (db[6] == 0) ? 32'hFFFFFFFF : da[6] / db[6];
  assign i_div_remainder = (db[6] == 0) ? da[6] : da[6] % db[6];

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          due;
    int          id;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   nid = 0;
  logic chk_busy = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL spurious_valid: got tag %0d result %h want none",
                   o_tag, o_result);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("result#%0d", mon_e.id), o_result, mon_e.res);
          chk($sformatf("tag#%0d", mon_e.id), {27'd0, o_tag},
              {27'd0, mon_e.tag});
          chk($sformatf("cycle#%0d", mon_e.id), cyc, mon_e.due);
        end
      end else begin
        chk("idle_result", o_result, 32'd0);
        chk("idle_tag", {27'd0, o_tag}, 32'd0);
      end
      if (chk_busy) chk("busy_inflight", {31'd0, o_busy}, 32'd1);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] res, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_flush = 1'b0;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_tag   = tag;
    if (push) begin
      e.res = res;
      e.tag = tag;
      e.due = cyc + LAT;
      e.id  = nid;
      nid++;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_op    = 2'b00;
    i_rs1   = '0;
    i_rs2   = '0;
    i_tag   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    chk("reset_tag", {27'd0, o_tag}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    mon_en = 1'b1;

    // Single signed divide plus front-end magnitudes.
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 1);
    #1;
    chk("fe_dividend_neg", o_div_dividend, 32'd7);
    chk("fe_divisor_pos", o_div_divisor, 32'd2);
    idle();
    drain();

    // Eight mixed ops back to back.
    issue(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF, 1);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1);
    chk_busy = 1'b1;
    issue(OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 1);
    issue(OP_DIVU, 32'hFFFFFFFE, 32'd2, 5'd7, 32'h7FFFFFFF, 1);
    issue(OP_DIV, 32'd5, 32'd0, 5'd8, 32'hFFFFFFFF, 1);
    issue(OP_REM, 32'hFFFFFFFB, 32'd0, 5'd9, 32'hFFFFFFFB, 1);
    issue(OP_REMU, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    #1;
    chk("fe_intmin", o_div_dividend, 32'h80000000);
    chk("fe_minus1", o_div_divisor, 32'd1);
    idle();
    drain();
    chk_busy = 1'b0;
    @(negedge clk);
    chk("busy_after_drain", {31'd0, o_busy}, 32'd0);

    // Remaining sign corners with gaps.
    issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1);
    idle();
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 1);
    #1;
    chk("fe_divisor_neg", o_div_divisor, 32'd2);
    idle();
    issue(OP_REM, 32'd7, 32'hFFFFFFFE, 5'd14, 32'd1, 1);
    issue(OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd15, 32'd3, 1);
    issue(OP_REM, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd16, 32'hFFFFFFFF, 1);
    issue(OP_DIVU, 32'hFFFFFFF9, 32'd2, 5'd17, 32'h7FFFFFFC, 1);
    #1;
    chk("fe_unsigned_pass", o_div_dividend, 32'hFFFFFFF9);
    issue(OP_REMU, 32'hFFFFFFF9, 32'd2, 5'd18, 32'd1, 1);
    idle();
    drain();

    // Flush kills three in-flight ops and the same-cycle issue.
    repeat (3) idle();
    issue(OP_DIV, 32'd40, 32'd4, 5'd20, 32'd0, 0);
    issue(OP_DIV, 32'd41, 32'd4, 5'd21, 32'd0, 0);
    issue(OP_DIV, 32'd42, 32'd4, 5'd22, 32'd0, 0);
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_tag   = 5'd23;
    @(negedge clk);
    chk("busy_pre_flush", {31'd0, o_busy}, 32'd1);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd24, 32'd14, 1);
    @(negedge clk);
    chk("busy_post_flush", {31'd0, o_busy}, 32'd0);
    idle();
    drain();

    // Reset mid-flight drops everything.
    repeat (3) idle();
    issue(OP_DIV, 32'd9, 32'd3, 5'd25, 32'd0, 0);
    issue(OP_REM, 32'd9, 32'd3, 5'd26, 32'd0, 0);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd27, 32'd0, 0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_mid_result", o_result, 32'd0);
    chk("rst_mid_tag", {27'd0, o_tag}, 32'd0);
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    repeat (LAT + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
